// File: rtl/alu_muldiv_seq.sv
// Sequencer that borrows the 8-bit ALU to run an 8x8 unsigned shift-add
// multiply or a 16/8 unsigned restoring divide. The ALU result is registered,
// so every operation issued in one state is consumed in the following state.
module alu_muldiv_seq #(
    parameter int ITER = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmd,
    input  logic [15:0] opa,
    input  logic [7:0]  opb,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  res_hi,
    output logic [7:0]  res_lo,
    output logic [3:0]  alu_op,
    output logic        alu_right,
    output logic [7:0]  alu_ai,
    output logic [7:0]  alu_bi,
    output logic        alu_ci,
    output logic        alu_bcd,
    input  logic [7:0]  alu_out,
    input  logic        alu_co
);

    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1111;
    localparam logic [3:0] OP_IDLE = 4'b1111;
    localparam logic [2:0] LAST    = 3'(ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_ADD,
        S_MUL_SHR,
        S_DIV_SHL,
        S_DIV_SUB,
        S_FINISH,
        S_ERR
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        is_div_q;
    logic [7:0]  b_q;       // multiplicand
    logic [7:0]  m_q;       // multiplier, becomes product low byte
    logic [7:0]  r_q;       // partial remainder as latched / last shifted
    logic [7:0]  q_q;       // dividend low byte, becomes quotient
    logic [7:0]  d_q;       // divisor
    logic [7:0]  t_q;       // shifted remainder before the trial subtract
    logic        s_q;       // bit shifted out of the remainder
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  res_hi_q;
    logic [7:0]  res_lo_q;

    // Outcome of the previous trial subtract: a shifted-out bit means the
    // 9-bit remainder certainly exceeds the divisor, so subtract regardless.
    logic        div_qb;
    logic [7:0]  div_r;
    logic [7:0]  div_q;
    logic [7:0]  shl_r;
    logic [7:0]  shl_q;

    // Resolve the pending quotient bit and pick the remainder for the next shift.
    always_comb begin
        div_qb = s_q | alu_co;
        div_r  = div_qb ? alu_out : t_q;
        div_q  = {q_q[7:1], div_qb};
        shl_r  = (cnt_q == 3'd0) ? r_q : div_r;
        shl_q  = (cnt_q == 3'd0) ? q_q : div_q;
    end

    // ALU control is combinational because each step feeds alu_out straight back in.
    always_comb begin
        alu_op    = OP_IDLE;
        alu_right = 1'b0;
        alu_ai    = 8'h00;
        alu_bi    = 8'h00;
        alu_ci    = 1'b0;
        case (state_q)
            S_MUL_ADD: begin
                alu_op = OP_ADD;
                alu_ai = (cnt_q == 3'd0) ? 8'h00 : alu_out;
                alu_bi = m_q[0] ? b_q : 8'h00;
            end
            S_MUL_SHR: begin
                alu_op    = OP_SHR;
                alu_right = 1'b1;
                alu_ai    = alu_out;
                alu_ci    = alu_co;
            end
            S_DIV_SHL: begin
                alu_op = OP_SHL;
                alu_ai = shl_r;
                alu_ci = shl_q[7];
            end
            S_DIV_SUB: begin
                alu_op = OP_SUB;
                alu_ai = alu_out;
                alu_bi = d_q;
                alu_ci = 1'b1;
            end
            default: ;
        endcase
    end

    // Main sequencer: operand latching, iteration control and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            is_div_q <= 1'b0;
            b_q      <= 8'h00;
            m_q      <= 8'h00;
            r_q      <= 8'h00;
            q_q      <= 8'h00;
            d_q      <= 8'h00;
            t_q      <= 8'h00;
            s_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            res_hi_q <= 8'h00;
            res_lo_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        res_hi_q <= 8'h00;
                        res_lo_q <= 8'h00;
                        cnt_q    <= 3'd0;
                        is_div_q <= cmd;
                        if (!cmd) begin
                            b_q     <= opa[7:0];
                            m_q     <= opb;
                            state_q <= S_MUL_ADD;
                        end else if (opb == 8'h00 || opa[15:8] >= opb) begin
                            state_q <= S_ERR;
                        end else begin
                            r_q     <= opa[15:8];
                            q_q     <= opa[7:0];
                            d_q     <= opb;
                            t_q     <= 8'h00;
                            s_q     <= 1'b0;
                            state_q <= S_DIV_SHL;
                        end
                    end
                end
                S_MUL_ADD: begin
                    state_q <= S_MUL_SHR;
                end
                S_MUL_SHR: begin
                    m_q     <= {alu_out[0], m_q[7:1]};
                    cnt_q   <= cnt_q + 3'd1;
                    state_q <= (cnt_q == LAST) ? S_FINISH : S_MUL_ADD;
                end
                S_DIV_SHL: begin
                    r_q     <= shl_r;
                    q_q     <= {shl_q[6:0], 1'b0};
                    state_q <= S_DIV_SUB;
                end
                S_DIV_SUB: begin
                    t_q     <= alu_out;
                    s_q     <= alu_co;
                    cnt_q   <= cnt_q + 3'd1;
                    state_q <= (cnt_q == LAST) ? S_FINISH : S_DIV_SHL;
                end
                S_FINISH: begin
                    if (is_div_q) begin
                        res_hi_q <= div_r;
                        res_lo_q <= div_q;
                    end else begin
                        res_hi_q <= alu_out;
                        res_lo_q <= m_q;
                    end
                    err_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    res_hi_q <= 8'h00;
                    res_lo_q <= 8'hFF;
                    err_q    <= 1'b1;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign res_hi  = res_hi_q;
    assign res_lo  = res_lo_q;
    assign alu_bcd = 1'b0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a registered ALU model attached.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cmd;
    logic [15:0] opa;
    logic [7:0]  opb;
    logic        busy, done, err;
    logic [7:0]  res_hi, res_lo;
    logic [3:0]  alu_op;
    logic        alu_right, alu_ci, alu_bcd;
    logic [7:0]  alu_ai, alu_bi;
    logic [7:0]  alu_out;
    logic        alu_co;

    int unsigned cyc = 0;
    int checks = 0;
    int passed = 0;
    int txn = 0;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        e;
        int unsigned due;
    } exp_t;

    exp_t sb[$];

    alu_muldiv_seq #(.ITER(8)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .err(err), .res_hi(res_hi), .res_lo(res_lo),
        .alu_op(alu_op), .alu_right(alu_right), .alu_ai(alu_ai), .alu_bi(alu_bi),
        .alu_ci(alu_ci), .alu_bcd(alu_bcd), .alu_out(alu_out), .alu_co(alu_co)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 6502-style ALU: logic stage on op[1:0], adder B source on op[3:2]; returns {co, out}.
    function automatic logic [8:0] alu_eval(input logic [3:0] op, input logic right,
                                            input logic [7:0] ai, input logic [7:0] bi,
                                            input logic ci);
        logic [7:0] t;
        logic [7:0] bb;
        if (right) return {ai[0], ci, ai[7:1]};
        case (op[1:0])
            2'd0:    t = ai | bi;
            2'd1:    t = ai & bi;
            2'd2:    t = ai ^ bi;
            default: t = ai;
        endcase
        case (op[3:2])
            2'd0:    bb = bi;
            2'd1:    bb = ~bi;
            2'd2:    bb = t;
            default: bb = 8'h00;
        endcase
        return {1'b0, t} + {1'b0, bb} + {8'd0, ci};
    endfunction

    always @(posedge clk) begin
        if (reset) {alu_co, alu_out} <= 9'd0;
        else       {alu_co, alu_out} <= alu_eval(alu_op, alu_right, alu_ai, alu_bi, alu_ci);
    end

    // Reference: plain arithmetic; due holds the accept-to-done latency in edges.
    function automatic exp_t model(input logic c, input logic [15:0] a, input logic [7:0] b);
        exp_t r;
        int unsigned p;
        if (!c) begin
            p = int'(a[7:0]) * int'(b);
            r.hi = p[15:8]; r.lo = p[7:0]; r.e = 1'b0; r.due = 17;
        end else if (b == 0 || (int'(a) / int'(b)) > 255) begin
            r.hi = 8'h00; r.lo = 8'hFF; r.e = 1'b1; r.due = 1;
        end else begin
            p = int'(a) / int'(b);
            r.lo = p[7:0];
            p = int'(a) % int'(b);
            r.hi = p[7:0]; r.e = 1'b0; r.due = 17;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                txn++;
                $display("txn %0d: cyc=%0d res_hi=%02h res_lo=%02h err=%0b", txn, cyc, res_hi, res_lo, err);
                check("res_hi", {24'd0, res_hi}, {24'd0, e.hi});
                check("res_lo", {24'd0, res_lo}, {24'd0, e.lo});
                check("err", {31'd0, err}, {31'd0, e.e});
                check("done_cycle", cyc, e.due);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic c, input logic [15:0] a, input logic [7:0] b,
                         input bit hold, output int unsigned acc);
        int guard;
        exp_t e;
        guard = 0;
        acc = 0;
        while (busy) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 100) begin
                check("accept_timeout", {31'd0, busy}, 32'd0);
                return;
            end
        end
        cmd = c; opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        e = model(c, a, b);
        e.due = cyc + e.due;
        sb.push_back(e);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        if (!hold) start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_res"}, {16'd0, res_hi, res_lo}, 32'd0);
        check({tag, "_alu_op"}, {28'd0, alu_op}, 32'hF);
        check({tag, "_alu_ctl"}, {14'd0, alu_right, alu_ai, alu_bi, alu_ci}, 32'd0);
        check({tag, "_bcd"}, {31'd0, alu_bcd}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k1, k2, dummy;
        int guard;
        logic c;
        logic [7:0] b;
        logic [15:0] a;
        bit h;

        reset = 1'b1; start = 1'b0; cmd = 1'b0; opa = 16'h0; opb = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        issue(1'b0, 16'h00FF, 8'hFF, 1'b0, dummy);
        issue(1'b0, 16'h000C, 8'h0D, 1'b0, dummy);
        issue(1'b0, 16'h000C, 8'h00, 1'b0, dummy);
        issue(1'b1, 16'h1234, 8'h56, 1'b0, dummy);
        issue(1'b1, 16'h1234, 8'h00, 1'b0, dummy);
        issue(1'b1, 16'h5600, 8'h56, 1'b0, dummy);
        issue(1'b1, 16'h55FF, 8'h56, 1'b0, dummy);

        // Start pulsed mid-operation must be ignored
        issue(1'b0, 16'h0037, 8'h5A, 1'b0, dummy);
        repeat (4) @(posedge clk);
        #1;
        cmd = 1'b1; opa = 16'h0100; opb = 8'h00; start = 1'b1;
        check("busy_at_ignored_start", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;

        // Back-to-back with start held across done
        issue(1'b0, 16'h00A5, 8'h3C, 1'b1, k1);
        issue(1'b1, 16'hBEEF, 8'hC1, 1'b1, k2);
        check("b2b_accept_cycle", k2, k1 + 18);
        issue(1'b1, 16'h7700, 8'h10, 1'b1, k1);
        issue(1'b0, 16'h0081, 8'h81, 1'b0, k2);
        check("b2b_err_accept_cycle", k2, k1 + 2);

        // Reset mid-operation aborts without a done pulse
        issue(1'b0, 16'h0077, 8'h99, 1'b0, dummy);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        check_idle_outputs("midreset");
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            c = 1'($urandom_range(0, 1));
            b = 8'($urandom_range(0, 255));
            a = 16'($urandom);
            if (c && $urandom_range(0, 5) != 0) begin
                if (b == 8'h00) b = 8'($urandom_range(1, 255));
                a[15:8] = 8'($urandom % int'(b));
            end
            h = (i != 39) && ($urandom_range(0, 3) == 0);
            issue(c, a, b, h, dummy);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
